// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and iteration constants for the mul/div unit
package muldiv_pkg;
    localparam int ITER_N = 32;
    localparam int CNT_W = 6;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide
module muldiv_step (
    input  logic [63:0] p,
    input  logic [31:0] b,
    input  logic        is_div,
    output logic [63:0] p_next
);
    logic [32:0] sum;
    logic [32:0] diff;
    always_comb begin
        sum = {1'b0, p[63:32]} + {1'b0, b};
        diff = p[63:31] - {1'b0, b};
        p_next = is_div ? (diff[32] ? {p[62:0], 1'b0} : {diff[31:0], p[30:0], 1'b1})
                        : (p[0] ? {sum, p[31:1]} : {1'b0, p[63:1]});
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 32-bit mul/div controller with HI/LO registers and pipeline stall/flush
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0] p_q, p_d, p_step, prod;
    logic [31:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b;
    logic div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
    logic is_signed, is_div, sa, sb;

    muldiv_step u_step (.p(p_q), .b(b_q), .is_div(div_q), .p_next(p_step));

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        p_d = p_q;
        b_d = b_q;
        div_d = div_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        hi_d = hi_q;
        lo_d = lo_q;
        done_d = 1'b0;
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        sa = is_signed & busA[31];
        sb = is_signed & busB[31];
        abs_a = sa ? -busA : busA;
        abs_b = sb ? -busB : busB;
        prod = qneg_q ? -p_q : p_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && op == OP_MTHI) begin
                        hi_d = busA;
                    end else if (start && op == OP_MTLO) begin
                        lo_d = busA;
                    end else if (start && !op[2]) begin
                        state_d = S_CALC;
                        cnt_d = '0;
                        p_d = {32'b0, abs_a};
                        b_d = abs_b;
                        div_d = is_div;
                        // divide by zero keeps the all-ones quotient unsigned-looking
                        qneg_d = (sa ^ sb) & ~(is_div & (busB == 32'b0));
                        rneg_d = sa;
                    end
                end
                S_CALC: begin
                    p_d = p_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER_N - 1)) state_d = S_FIX;
                end
                S_FIX: begin
                    state_d = S_IDLE;
                    done_d = 1'b1;
                    hi_d = div_q ? (rneg_q ? -p_q[63:32] : p_q[63:32]) : prod[63:32];
                    lo_d = div_q ? (qneg_q ? -p_q[31:0] : p_q[31:0]) : prod[31:0];
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            p_q <= '0;
            b_q <= '0;
            div_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            p_q <= p_d;
            b_q <= b_d;
            div_q <= div_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            done_q <= done_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);
endmodule
